// File: rtl/ttl74x190_updown_decade.sv
// ttl74x190_updown_decade
//   Synchronous up/down BCD decade counter modelled on the SN74LS190.
//   The parallel load is synchronous (single-clock FPGA style).
//   To cascade digits, drive the next digit's CTEN_n from this digit's RCO_n.
//   Both digits share clk.
//
// Ports
//   clk      rising-edge clock
//   MR_n     asynchronous active-low master clear (Q=0)
//   PL_n     active-low synchronous parallel load of P
//   CTEN_n   active-low count enable
//   D_U      direction: 0 = up, 1 = down
//   P[3:0]   parallel load data; any code 0..15 is accepted
//   Q[3:0]   current count
//   MAX_MIN  terminal state for the current direction (9 going up, 0 going down)
//   RCO_n    active-low ripple carry/borrow = ~(MAX_MIN & ~CTEN_n)
//   ERR      sticky invalid-code flag, present only when TTL74X190_ERR_FLAG_EN
//            is defined
//
// Optional feature macro: TTL74X190_ERR_FLAG_EN
module ttl74x190_updown_decade #(
  localparam int         WIDTH     = 4,
  localparam logic [3:0] MAX_COUNT = 4'd9
) (
  input  logic             clk,
  input  logic             MR_n,
  input  logic             PL_n,
  input  logic             CTEN_n,
  input  logic             D_U,
  input  logic [WIDTH-1:0] P,
  output logic [WIDTH-1:0] Q,
  output logic             MAX_MIN,
  output logic             RCO_n
`ifdef TTL74X190_ERR_FLAG_EN
  ,
  output logic             ERR
`endif
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             q_invalid;

  assign q_invalid = (q_q > MAX_COUNT);

  // Codes 10..15 can only come from a load.
  // A count always lands back in 0..9: up goes to 0, down goes to 9.
  always_comb begin
    q_d = q_q;
    if (!PL_n) begin
      q_d = P;
    end else if (!CTEN_n) begin
      if (!D_U) begin
        q_d = (q_q >= MAX_COUNT) ? '0 : q_q + 4'd1;
      end else begin
        q_d = ((q_q == '0) || q_invalid) ? MAX_COUNT : q_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge MR_n) begin
    if (!MR_n) q_q <= '0;
    else       q_q <= q_d;
  end

  assign Q = q_q;

  // The direction is not latched, so MAX_MIN tracks D_U combinationally.
  // During reset Q=0, so this reduces to MAX_MIN = D_U.
  assign MAX_MIN = (!D_U && (q_q == MAX_COUNT)) || (D_U && (q_q == '0));

  // RCO_n is not gated by the clock: it stays low for the whole terminal cycle.
  // This lets the next digit advance on the same edge that wraps this digit.
  assign RCO_n = ~(MAX_MIN & ~CTEN_n);

`ifdef TTL74X190_ERR_FLAG_EN
  logic err_q, err_d;

  // Loading a valid code clears the flag, and the clear takes priority.
  // Recovering through a count does not clear it.
  // Holding an invalid code across any other edge sets it.
  always_comb begin
    err_d = err_q;
    if (!PL_n && (P <= MAX_COUNT)) err_d = 1'b0;
    else if (q_invalid)            err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge MR_n) begin
    if (!MR_n) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign ERR = err_q;
`endif

endmodule
